// File: rtl/mem_access_unit_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_unit_pkg
//  Shared encodings for the MEM-stage load/store engine. The decoder and the
//  WB stage use the same MEM_TYPE_* codes.
//   - MEM_TYPE_* : decoder memory-type codes ([2]=sign-extend, [1:0]=size)
//   - SIZE_*     : bus transfer size codes
//   - mau_state_e: access engine states
//   - is_misaligned / replicate_store: helpers used by the top
// ---------------------------------------------------------------------------
package mem_access_unit_pkg;

   localparam logic [2:0] MEM_TYPE_LB   = 3'b100;
   localparam logic [2:0] MEM_TYPE_LBU  = 3'b000;
   localparam logic [2:0] MEM_TYPE_SB   = 3'b000;
   localparam logic [2:0] MEM_TYPE_LH   = 3'b101;
   localparam logic [2:0] MEM_TYPE_LHU  = 3'b001;
   localparam logic [2:0] MEM_TYPE_SH   = 3'b001;
   localparam logic [2:0] MEM_TYPE_LW   = 3'b010;
   localparam logic [2:0] MEM_TYPE_SW   = 3'b010;
   localparam logic [2:0] MEM_TYPE_NONE = 3'b111;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ADDR = 2'b01,
      ST_DATA = 2'b10,
      ST_HOLD = 2'b11
   } mau_state_e;

   // Half accesses need bit 0 clear, word accesses need bits 1:0 clear.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic mis;
      case (size)
         SIZE_HALF: mis = addr_lo[0];
         SIZE_WORD: mis = (addr_lo != 2'b00);
         default:   mis = 1'b0;
      endcase
      return mis;
   endfunction

   // Copy the store operand into every lane so the memory picks the right
   // lane from the address alone.
   function automatic logic [31:0] replicate_store(input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] rep;
      case (size)
         SIZE_BYTE: rep = {4{wdata[7:0]}};
         SIZE_HALF: rep = {2{wdata[15:0]}};
         default:   rep = wdata;
      endcase
      return rep;
   endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// ---------------------------------------------------------------------------
// mem_access_unit_load_align
//  Combinational load-lane extraction and extension.
//   rdata   in  32  raw bus read word
//   addr_lo in  2   byte offset of the access
//   size    in  2   SIZE_* code
//   sign    in  1   1 = sign-extend, 0 = zero-extend
//   result  out 32  aligned, extended load value
// ---------------------------------------------------------------------------
module mem_access_unit_load_align
   import mem_access_unit_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        sign,
   output logic [31:0] result
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Select the addressed lane and extend it to 32 bits.
   always_comb begin
      byte_s = 8'h00;
      half_s = 16'h0000;
      result = 32'h0000_0000;
      case (addr_lo)
         2'b00:   byte_s = rdata[7:0];
         2'b01:   byte_s = rdata[15:8];
         2'b10:   byte_s = rdata[23:16];
         2'b11:   byte_s = rdata[31:24];
         default: byte_s = 8'h00;
      endcase
      if (addr_lo[1]) begin
         half_s = rdata[31:16];
      end else begin
         half_s = rdata[15:0];
      end
      case (size)
         SIZE_BYTE: result = {{24{sign & byte_s[7]}}, byte_s};
         SIZE_HALF: result = {{16{sign & half_s[15]}}, half_s};
         default:   result = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//  MEM-stage load/store engine on an sram-like bus (req/addr_ok, data_ok).
//  Stalls the pipeline until the access completes, flags misaligned
//  accesses and returns the aligned, extended load value to WB.
//   clk, resetn          clock, synchronous active-low reset
//   mem_read/mem_write   MEM-stage load/store; mem_type = {sign, size}
//   addr, wdata          effective address, store operand
//   flush, advance       pipeline cancel, MEM->WB update
//   stall, load_data     pipeline hold, load result (valid in HOLD)
//   adel, ades           misaligned load/store (combinational, IDLE only)
//   data_*               bus request side and response side
// ---------------------------------------------------------------------------
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [2:0]        mem_type,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   input  logic              flush,
   input  logic              advance,
   output logic              stall,
   output logic [31:0]       load_data,
   output logic              adel,
   output logic              ades,
   output logic              data_req,
   output logic              data_wr,
   output logic [1:0]        data_size,
   output logic [ADDR_W-1:0] data_addr,
   output logic [31:0]       data_wdata,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   input  logic [31:0]       data_rdata
);

   mau_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        size_q, size_d;
   logic              wr_q, wr_d;
   logic              sign_q, sign_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              cancel_q, cancel_d;
   logic [31:0]       load_data_q, load_data_d;

   logic              op_s;
   logic              misaligned_s;
   logic              launch_s;
   logic [31:0]       align_res_s;

   mem_access_unit_load_align u_load_align (
      .rdata   (data_rdata),
      .addr_lo (addr_q[1:0]),
      .size    (size_q),
      .sign    (sign_q),
      .result  (align_res_s)
   );

   // Decode the incoming MEM-stage request.
   always_comb begin
      op_s         = (mem_read | mem_write) & (mem_type != MEM_TYPE_NONE);
      misaligned_s = is_misaligned(mem_type[1:0], addr[1:0]);
      launch_s     = (state_q == ST_IDLE) & op_s & ~misaligned_s & ~flush;
   end

   // Next-state and captured-field logic.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      size_d      = size_q;
      wr_d        = wr_q;
      sign_d      = sign_q;
      wdata_d     = wdata_q;
      cancel_d    = cancel_q;
      load_data_d = load_data_q;
      case (state_q)
         ST_IDLE: begin
            cancel_d = 1'b0;
            if (launch_s) begin
               addr_d  = addr;
               size_d  = mem_type[1:0];
               wr_d    = mem_write;
               sign_d  = mem_type[2];
               wdata_d = replicate_store(mem_type[1:0], wdata);
               state_d = ST_ADDR;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ADDR: begin
            // A flush cannot withdraw a posted request; remember it and drain.
            if (flush) begin
               cancel_d = 1'b1;
            end else begin
               cancel_d = cancel_q;
            end
            if (data_addr_ok) begin
               state_d = ST_DATA;
            end else begin
               state_d = ST_ADDR;
            end
         end
         ST_DATA: begin
            if (data_data_ok) begin
               if (cancel_q | flush) begin
                  cancel_d = 1'b0;
                  state_d  = ST_IDLE;
               end else begin
                  state_d = ST_HOLD;
                  if (!wr_q) begin
                     load_data_d = align_res_s;
                  end else begin
                     load_data_d = load_data_q;
                  end
               end
            end else begin
               if (flush) begin
                  cancel_d = 1'b1;
               end else begin
                  cancel_d = cancel_q;
               end
               state_d = ST_DATA;
            end
         end
         ST_HOLD: begin
            // Wait for WB to take the result; never re-issue from here.
            if (advance | flush) begin
               cancel_d = 1'b0;
               state_d  = ST_IDLE;
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            cancel_d = 1'b0;
            state_d  = ST_IDLE;
         end
      endcase
   end

   // State and captured-field registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         addr_q      <= {ADDR_W{1'b0}};
         size_q      <= 2'b00;
         wr_q        <= 1'b0;
         sign_q      <= 1'b0;
         wdata_q     <= 32'h0000_0000;
         cancel_q    <= 1'b0;
         load_data_q <= 32'h0000_0000;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         size_q      <= size_d;
         wr_q        <= wr_d;
         sign_q      <= sign_d;
         wdata_q     <= wdata_d;
         cancel_q    <= cancel_d;
         load_data_q <= load_data_d;
      end
   end

   // Pipeline and exception outputs.
   always_comb begin
      stall = launch_s | (state_q == ST_ADDR) | (state_q == ST_DATA);
      adel  = (state_q == ST_IDLE) & op_s & misaligned_s & mem_read;
      ades  = (state_q == ST_IDLE) & op_s & misaligned_s & mem_write;
   end

   // Bus request fields come straight from the captured registers.
   always_comb begin
      data_req   = (state_q == ST_ADDR);
      data_wr    = wr_q;
      data_size  = size_q;
      data_addr  = addr_q;
      data_wdata = wdata_q;
      load_data  = load_data_q;
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus a
// randomized run against a behavioural model of the load/store rules.
module tb_mem_access_unit;

   localparam logic [2:0] T_LB = 3'b100, T_LBU = 3'b000, T_LH = 3'b101, T_LHU = 3'b001;
   localparam logic [2:0] T_W  = 3'b010, T_NONE = 3'b111;

   logic        clk = 1'b0;
   logic        resetn;
   logic        mem_read, mem_write;
   logic [2:0]  mem_type;
   logic [31:0] addr, wdata;
   logic        flush, advance;
   logic        stall;
   logic [31:0] load_data;
   logic        adel, ades;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] model_ld;

   typedef struct {
      int          n_stall;
      int          n_req;
      logic        adel;
      logic        ades;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic        wr;
      logic        stable;
      logic        timeout;
   } obs_t;

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_W(32)) dut (
      .clk(clk), .resetn(resetn), .mem_read(mem_read), .mem_write(mem_write),
      .mem_type(mem_type), .addr(addr), .wdata(wdata), .flush(flush), .advance(advance),
      .stall(stall), .load_data(load_data), .adel(adel), .ades(ades),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .data_rdata(data_rdata)
   );

   // Reference: pick the naturally aligned lane and extend it.
   function automatic logic [31:0] ref_load(input logic [2:0] typ, input logic [31:0] a, input logic [31:0] rd);
      int nb, off;
      longint unsigned v, mask;
      nb   = 1 << typ[1:0];
      off  = ((a % 4) / nb) * nb;
      mask = (64'd1 << (8 * nb)) - 64'd1;
      v    = ({32'd0, rd} >> (8 * off)) & mask;
      if (typ[2] && v >= (mask + 64'd1) / 64'd2) v = v - (mask + 64'd1);
      return v[31:0];
   endfunction

   function automatic logic [31:0] ref_store(input logic [2:0] typ, input logic [31:0] wd);
      int nb;
      nb = 1 << typ[1:0];
      if (nb == 1) return (wd % 256) * 32'h0101_0101;
      if (nb == 2) return (wd % 65536) * 32'h0001_0001;
      return wd;
   endfunction

   function automatic bit ref_mis(input logic [2:0] typ, input logic [31:0] a);
      return (a % (1 << typ[1:0])) != 0;
   endfunction

   task automatic idle_inputs();
      mem_read = 1'b0; mem_write = 1'b0; mem_type = T_NONE;
      flush = 1'b0; advance = 1'b0;
   endtask

   // Drives one access and acts as the bus slave; returns observations.
   task automatic run_access(input logic mr, input logic mw, input logic [2:0] typ,
                             input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                             input int aw, input int dw, input int fl, output obs_t o);
      int  k;
      bit  in_addr, done;
      o.n_stall = 0; o.n_req = 0; o.stable = 1'b1; o.timeout = 1'b0;
      o.addr = 32'h0; o.wdata = 32'h0; o.size = 2'b00; o.wr = 1'b0;
      @(negedge clk);
      idle_inputs();
      mem_read = mr; mem_write = mw; mem_type = typ; addr = a; wdata = wd;
      #1;
      o.adel = adel; o.ades = ades;
      if (data_req) o.n_req++;
      if (!stall) begin
         @(negedge clk);
         idle_inputs();
         return;
      end
      o.n_stall++;
      in_addr = 1'b1; done = 1'b0; k = 0;
      for (int c = 0; c < 100 && !done; c++) begin
         @(negedge clk);
         mem_read = 1'b0; mem_write = 1'b0; mem_type = T_NONE;
         if (in_addr) begin
            flush = (k == fl); data_addr_ok = (k >= aw);
         end else begin
            flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = (k >= dw); data_rdata = rd;
         end
         #1;
         if (stall) o.n_stall++;
         if (data_req) begin
            if (o.n_req == 0) begin
               o.addr = data_addr; o.wdata = data_wdata; o.size = data_size; o.wr = data_wr;
            end else if (o.addr !== data_addr || o.wdata !== data_wdata || o.size !== data_size || o.wr !== data_wr) begin
               o.stable = 1'b0;
            end
            o.n_req++;
         end
         if (in_addr && data_addr_ok) begin
            in_addr = 1'b0; k = 0;
         end else if (!in_addr && data_data_ok) begin
            done = 1'b1;
         end else begin
            k++;
         end
      end
      @(negedge clk);
      data_addr_ok = 1'b0; data_data_ok = 1'b0; flush = 1'b0;
      #1;
      o.timeout = !done;
   endtask

   task automatic pulse_advance();
      @(negedge clk); advance = 1'b1;
      @(negedge clk); advance = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0; idle_inputs(); addr = 32'h0; wdata = 32'h0;
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
      repeat (3) @(negedge clk);
      #1;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %0b want 0", stall); end
      n_checks++; if (data_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %0b want 0", data_req); end
      n_checks++; if (data_wr !== 1'b0) begin n_fail++; $display("FAIL reset_wr got %0b want 0", data_wr); end
      n_checks++; if (adel !== 1'b0 || ades !== 1'b0) begin n_fail++; $display("FAIL reset_adex got %0b%0b want 00", adel, ades); end
      n_checks++; if (load_data !== 32'h0) begin n_fail++; $display("FAIL reset_load_data got %h want 0", load_data); end
      resetn = 1'b1;
      model_ld = 32'h0;
   endtask

   task automatic test_lw();
      obs_t o;
      run_access(1'b1, 1'b0, T_W, 32'h1000, 32'h0, 32'hDEAD_BEEF, 0, 0, -1, o);
      model_ld = 32'hDEAD_BEEF;
      n_checks++; if (o.n_stall !== 3) begin n_fail++; $display("FAIL lw_stall_cycles got %0d want 3", o.n_stall); end
      n_checks++; if (o.n_req !== 1) begin n_fail++; $display("FAIL lw_req_cycles got %0d want 1", o.n_req); end
      n_checks++; if (o.addr !== 32'h1000 || o.size !== 2'b10 || o.wr !== 1'b0) begin
         n_fail++; $display("FAIL lw_bus got addr=%h size=%b wr=%b want 1000/10/0", o.addr, o.size, o.wr); end
      n_checks++; if (stall !== 1'b0 || load_data !== model_ld) begin
         n_fail++; $display("FAIL lw_hold got stall=%b data=%h want 0/%h", stall, load_data, model_ld); end
      n_checks++; if (o.timeout !== 1'b0) begin n_fail++; $display("FAIL lw_timeout got 1 want 0"); end
      pulse_advance();
   endtask

   task automatic test_load_ext();
      obs_t o;
      logic [2:0]  typs [3] = '{T_LB, T_LBU, T_LH};
      logic [31:0] as   [3] = '{32'h1003, 32'h1003, 32'h1002};
      logic [31:0] rds  [3] = '{32'h80FF_FF7F, 32'h80FF_FF7F, 32'h8001_0000};
      logic [31:0] exps [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001};
      for (int i = 0; i < 3; i++) begin
         run_access(1'b1, 1'b0, typs[i], as[i], 32'h0, rds[i], 0, 1, -1, o);
         model_ld = exps[i];
         n_checks++; if (load_data !== exps[i]) begin
            n_fail++; $display("FAIL load_ext_%0d got %h want %h", i, load_data, exps[i]); end
         n_checks++; if (o.n_stall !== 4) begin
            n_fail++; $display("FAIL load_ext_stall_%0d got %0d want 4", i, o.n_stall); end
         pulse_advance();
      end
   endtask

   task automatic test_store();
      obs_t o;
      run_access(1'b0, 1'b1, T_LBU, 32'h2001, 32'h1234_5678, 32'h0, 1, 0, -1, o);
      n_checks++; if (o.wr !== 1'b1 || o.size !== 2'b00) begin
         n_fail++; $display("FAIL sb_ctl got wr=%b size=%b want 1/00", o.wr, o.size); end
      n_checks++; if (o.wdata !== 32'h7878_7878 || o.addr !== 32'h2001) begin
         n_fail++; $display("FAIL sb_data got wdata=%h addr=%h want 78787878/2001", o.wdata, o.addr); end
      n_checks++; if (o.stable !== 1'b1 || o.n_req !== 2) begin
         n_fail++; $display("FAIL sb_req_hold got stable=%b req=%0d want 1/2", o.stable, o.n_req); end
      n_checks++; if (load_data !== model_ld) begin
         n_fail++; $display("FAIL sb_load_data got %h want %h", load_data, model_ld); end
      pulse_advance();
   endtask

   task automatic test_misaligned();
      obs_t o;
      run_access(1'b1, 1'b0, T_W, 32'h1002, 32'h0, 32'h0, 0, 0, -1, o);
      n_checks++; if (o.adel !== 1'b1 || o.ades !== 1'b0) begin
         n_fail++; $display("FAIL lw_adel got adel=%b ades=%b want 1/0", o.adel, o.ades); end
      n_checks++; if (o.n_req !== 0 || o.n_stall !== 0) begin
         n_fail++; $display("FAIL lw_mis_bus got req=%0d stall=%0d want 0/0", o.n_req, o.n_stall); end
      run_access(1'b0, 1'b1, T_LHU, 32'h2001, 32'hABCD, 32'h0, 0, 0, -1, o);
      n_checks++; if (o.ades !== 1'b1 || o.adel !== 1'b0) begin
         n_fail++; $display("FAIL sh_ades got ades=%b adel=%b want 1/0", o.ades, o.adel); end
      n_checks++; if (o.n_req !== 0) begin n_fail++; $display("FAIL sh_mis_req got %0d want 0", o.n_req); end
   endtask

   task automatic test_flush_drain();
      obs_t o;
      run_access(1'b1, 1'b0, T_W, 32'h1000, 32'h0, 32'h1111_2222, 4, 1, 1, o);
      n_checks++; if (o.n_req !== 5 || o.stable !== 1'b1) begin
         n_fail++; $display("FAIL flush_req got req=%0d stable=%b want 5/1", o.n_req, o.stable); end
      n_checks++; if (o.n_stall !== 8) begin n_fail++; $display("FAIL flush_stall got %0d want 8", o.n_stall); end
      n_checks++; if (load_data !== model_ld || stall !== 1'b0) begin
         n_fail++; $display("FAIL flush_load_data got %h stall=%b want %h/0", load_data, stall, model_ld); end
      // No advance: the unit must already be back in IDLE and accept the next load.
      run_access(1'b1, 1'b0, T_W, 32'h1004, 32'h0, 32'h55AA_55AA, 0, 0, -1, o);
      model_ld = 32'h55AA_55AA;
      n_checks++; if (o.n_stall !== 3 || load_data !== model_ld) begin
         n_fail++; $display("FAIL flush_next got stall=%0d data=%h want 3/%h", o.n_stall, load_data, model_ld); end
      pulse_advance();
   endtask

   task automatic test_hold();
      obs_t o;
      run_access(1'b1, 1'b0, T_W, 32'h3000, 32'h0, 32'hCAFE_F00D, 0, 0, -1, o);
      model_ld = 32'hCAFE_F00D;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         mem_read = 1'b1; mem_type = T_W; addr = 32'h3004;
         #1;
         n_checks++; if (data_req !== 1'b0 || stall !== 1'b0 || load_data !== model_ld) begin
            n_fail++; $display("FAIL hold_%0d got req=%b stall=%b data=%h want 0/0/%h", i, data_req, stall, load_data, model_ld); end
      end
      @(negedge clk); idle_inputs(); advance = 1'b1;
      @(negedge clk); advance = 1'b0;
      run_access(1'b1, 1'b0, T_W, 32'h3004, 32'h0, 32'h0BAD_CAFE, 0, 0, -1, o);
      model_ld = 32'h0BAD_CAFE;
      n_checks++; if (o.n_stall !== 3 || o.n_req !== 1 || load_data !== model_ld) begin
         n_fail++; $display("FAIL hold_next got stall=%0d req=%0d data=%h want 3/1/%h", o.n_stall, o.n_req, load_data, model_ld); end
      pulse_advance();
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      mem_read = 1'b1; mem_type = T_W; addr = 32'h4000;
      @(negedge clk);
      idle_inputs(); resetn = 1'b0;
      #1;
      n_checks++; if (data_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre got req=%b want 1", data_req); end
      @(negedge clk);
      #1;
      n_checks++; if (data_req !== 1'b0 || stall !== 1'b0 || load_data !== 32'h0) begin
         n_fail++; $display("FAIL rst_mid got req=%b stall=%b data=%h want 0/0/0", data_req, stall, load_data); end
      resetn = 1'b1;
      model_ld = 32'h0;
   endtask

   task automatic test_random();
      obs_t o;
      logic [2:0]  typ;
      logic [31:0] a, wd, rd;
      bit          ld, mis, cancel;
      int          aw, dw, fl, sel;
      for (int it = 0; it < 40; it++) begin
         sel = $urandom_range(0, 7);
         ld  = (sel < 5);
         case (sel)
            0: typ = T_LB;  1: typ = T_LBU; 2: typ = T_LH; 3: typ = T_LHU; 4: typ = T_W;
            5: typ = T_LBU; 6: typ = T_LHU; default: typ = T_W;
         endcase
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a = a - (a % (1 << typ[1:0]));
         wd = $urandom; rd = $urandom;
         aw = $urandom_range(0, 3); dw = $urandom_range(0, 3);
         fl = ($urandom_range(0, 4) == 0) ? $urandom_range(0, aw) : -1;
         mis    = ref_mis(typ, a);
         cancel = (fl >= 0);
         run_access(ld, !ld, typ, a, wd, rd, aw, dw, fl, o);
         if (!mis && !cancel && ld) model_ld = ref_load(typ, a, rd);
         n_checks++; if (o.n_stall !== (mis ? 0 : 3 + aw + dw)) begin
            n_fail++; $display("FAIL rnd_stall_%0d got %0d want %0d", it, o.n_stall, mis ? 0 : 3 + aw + dw); end
         n_checks++; if (o.adel !== (mis & ld) || o.ades !== (mis & !ld)) begin
            n_fail++; $display("FAIL rnd_adex_%0d got %b%b want %b%b", it, o.adel, o.ades, mis & ld, mis & !ld); end
         n_checks++; if (load_data !== model_ld) begin
            n_fail++; $display("FAIL rnd_load_%0d got %h want %h (type %b addr %h)", it, load_data, model_ld, typ, a); end
         if (!mis) begin
            n_checks++; if (o.n_req !== aw + 1 || o.addr !== a || o.wr !== !ld || o.stable !== 1'b1) begin
               n_fail++; $display("FAIL rnd_bus_%0d got req=%0d addr=%h wr=%b stable=%b", it, o.n_req, o.addr, o.wr, o.stable); end
            if (!ld) begin
               n_checks++; if (o.wdata !== ref_store(typ, wd)) begin
                  n_fail++; $display("FAIL rnd_wdata_%0d got %h want %h", it, o.wdata, ref_store(typ, wd)); end
            end
            if (o.timeout) begin n_fail++; $display("FAIL rnd_timeout_%0d got timeout want completion", it); end
            if (!cancel) pulse_advance();
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_lw();
      test_load_ext();
      test_store();
      test_misaligned();
      test_flush_drain();
      test_hold();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
